ring_decoder8: RTL and testbench
================================

Name: ring_decoder8

Overview:
- Receive-side monitor for an 8-bit one-hot rotating ring value, such as the output of an up/down ring counter.
- Samples the ring word on each qualified clock and decodes the active bit to a 3-bit position.
- Infers rotation direction per sample and keeps a signed net-lap count.
- Detects illegal words (not one-hot) and illegal steps (jumps), then resynchronises automatically.

Parameters:
LAP_W, 8, width of the net-lap counter (two's complement, wraps).
ERR_W, 4, width of the saturating error counter.

Ports:
clk  input  1  single clock; all state changes on posedge clk.
reset  input  1  synchronous, active-high reset; sampled on posedge clk and overrides all other inputs.
valid  input  1  qualifies ring_in on this posedge.
ring_in  input  8  ring word under observation.
pos  output  3  index of the set bit in the last accepted one-hot word.
locked  output  1  1 while in TRACK state.
dir  output  2  result of last accepted step: 00 HOLD, 01 UP (left shift), 10 DOWN (right shift), 11 JUMP.
lap  output  LAP_W  net revolutions: +1 per 7->0 UP step, -1 per 0->7 DOWN step.
err  output  1  one-cycle pulse on any detected fault.
err_cnt  output  ERR_W  saturating count of faults.

Behaviour:
- Reset: on posedge clk with reset=1:
  - pos=0, locked=0, dir=00, lap=0, err=0, err_cnt=0.
  - State goes to IDLE.
  - The valid and ring_in inputs are ignored.
- Registered outputs, latency 1: a sample taken at edge k is reflected in the outputs immediately after edge k.
- valid=0: all state and outputs hold, except err, which is 0.
- One-hot check: legal only if exactly one bit of ring_in is set. 0x00 and any multi-bit word are illegal.
- Position decode: pos = index of the set bit (0x01->0, 0x80->7).
- States: IDLE, TRACK, FAULT.
- IDLE, valid=1:
  - Legal word: pos=decode, dir=HOLD, locked=1, go to TRACK. lap is unchanged.
  - Illegal word: err=1, err_cnt++, stay in IDLE, pos unchanged.
- TRACK, valid=1, legal word, with n = decoded index and p = current pos:
  - n==p: dir=HOLD.
  - n==(p+1) mod 8: dir=UP. If p==7 (so n==0), lap=lap+1.
  - n==(p-1) mod 8: dir=DOWN. If p==0 (so n==7), lap=lap-1.
  - Otherwise: dir=JUMP, err=1, err_cnt++, stay in TRACK.
  - pos=n in all cases, including JUMP (resync).
- TRACK, valid=1, illegal word: err=1, err_cnt++, go to FAULT, locked=0. pos, dir and lap hold.
- FAULT, valid=1:
  - Legal word: pos=decode, dir=HOLD, locked=1, go to TRACK. No lap change; no step is inferred across the fault.
  - Illegal word: err=1, err_cnt++, stay in FAULT.
- err_cnt saturates at 2^ERR_W-1; further faults still pulse err.
- lap arithmetic is modulo 2^LAP_W in two's complement: 0x7F+1 -> 0x80, 0x00-1 -> 0xFF (LAP_W=8).
- Reset mid-operation: takes effect on that edge regardless of state or valid. The next legal sample is treated as the first (IDLE path).
- err is never asserted in the cycle after reset.

Test Plan:
- Reset, then valid=1 with ring_in 0x01,0x02,0x04,...,0x80,0x01 -> pos 0..7,0; dir=01 after the first sample; lap=1 after the final 0x80->0x01 step; err never set.
- From locked pos=0, ring_in 0x80,0x40,0x80 -> dir 10,10,01; pos 7,6,7; lap goes 0 -> -1 (0xFF), then stays 0xFF.
- Locked at pos=2 (0x04), apply 0x04 with valid=1, then valid=0 with ring_in=0x00 for 3 cycles -> dir=00, pos=2, no err, outputs frozen throughout.
- Locked at pos=1, apply 0x10 -> dir=11, err pulse, err_cnt=1, pos=4, locked stays 1; then 0x20 -> dir=01, no err.
- Locked, apply 0x00 -> err, locked=0, state FAULT; then 0x03 -> err, err_cnt=2; then 0x08 -> locked=1, pos=3, dir=00, lap unchanged. Then drive 20 consecutive illegal words -> err_cnt saturates at 15.
- Drive 128 consecutive UP revolutions -> lap wraps 0x7F -> 0x80. Then assert reset with valid=1 and ring_in=0x02 on the same edge -> all outputs 0, locked=0; next 0x02 -> locked=1, pos=1.

Source files
------------

// File: rtl/ring_decoder8.sv
// Receive-side monitor for an 8-bit one-hot rotating ring: decodes position, infers step
// direction, keeps a signed net-lap count and flags illegal words and jumps.
module ring_decoder8 #(
    parameter int unsigned LAP_W = 8,
    parameter int unsigned ERR_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [7:0]       ring_in,
    output logic [2:0]       pos,
    output logic             locked,
    output logic [1:0]       dir,
    output logic [LAP_W-1:0] lap,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {StIdle, StTrack, StFault} state_e;

    localparam logic [1:0] DirHold = 2'b00;
    localparam logic [1:0] DirUp   = 2'b01;
    localparam logic [1:0] DirDown = 2'b10;
    localparam logic [1:0] DirJump = 2'b11;

    state_e             state_q, state_d;
    logic [2:0]         pos_q, pos_d;
    logic [1:0]         dir_q, dir_d;
    logic [LAP_W-1:0]   lap_q, lap_d;
    logic               err_q, err_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;

    logic               legal;
    logic [2:0]         idx;
    logic [2:0]         pos_inc;
    logic [2:0]         pos_dec;
    logic               fault;

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
    always_comb begin
        legal = (ring_in != 8'h00) && ((ring_in & (ring_in - 8'd1)) == 8'h00);
        idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (ring_in[i]) begin
                idx = 3'(i);
            end
        end
        pos_inc = pos_q + 3'd1;
        pos_dec = pos_q - 3'd1;
    end

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        lap_d   = lap_q;
        fault   = 1'b0;

        if (valid) begin
            unique case (state_q)
                StIdle, StFault: begin
                    // No step is inferred across a fault or from reset.
                    if (legal) begin
                        pos_d   = idx;
                        dir_d   = DirHold;
                        state_d = StTrack;
                    end else begin
                        fault = 1'b1;
                    end
                end
                StTrack: begin
                    if (!legal) begin
                        fault   = 1'b1;
                        state_d = StFault;
                    end else begin
                        pos_d = idx;
                        if (idx == pos_q) begin
                            dir_d = DirHold;
                        end else if (idx == pos_inc) begin
                            dir_d = DirUp;
                            if (pos_q == 3'd7) begin
                                lap_d = lap_q + LAP_W'(1);
                            end
                        end else if (idx == pos_dec) begin
                            dir_d = DirDown;
                            if (pos_q == 3'd0) begin
                                lap_d = lap_q - LAP_W'(1);
                            end
                        end else begin
                            dir_d = DirJump;
                            fault = 1'b1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        err_d     = fault;
        err_cnt_d = err_cnt_q;
        if (fault && (err_cnt_q != {ERR_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            pos_q     <= 3'd0;
            dir_q     <= DirHold;
            lap_q     <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            dir_q     <= dir_d;
            lap_q     <= lap_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign pos     = pos_q;
    assign locked  = (state_q == StTrack);
    assign dir     = dir_q;
    assign lap     = lap_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_ring_decoder8.sv
// Directed bench for ring_decoder8; observed outputs packed as
// {locked, err, dir, pos, lap, err_cnt} and compared against hand-computed vectors.
module tb_ring_decoder8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] ring_in = 8'h00;
    logic [2:0] pos;
    logic       locked;
    logic [1:0] dir;
    logic [7:0] lap;
    logic       err;
    logic [3:0] err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [18:0] obs;
    logic [18:0] exp_v;
    assign obs = {locked, err, dir, pos, lap, err_cnt};

    ring_decoder8 #(.LAP_W(8), .ERR_W(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .valid   (valid),
        .ring_in (ring_in),
        .pos     (pos),
        .locked  (locked),
        .dir     (dir),
        .lap     (lap),
        .err     (err),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    // Apply one sample across a posedge, then settle before the caller samples.
    task automatic step(input logic v, input logic [7:0] r);
        valid   = v;
        ring_in = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 8'h00);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(1'b0, 8'h00);
        step(1'b1, 8'h10);
        exp_v = {1'b0, 1'b0, 2'b00, 3'd0, 8'h00, 4'h0};
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL reset: got %h want %h", obs, exp_v);
        end
        reset = 1'b0;
        // Illegal word in IDLE: err pulse, count, still unlocked.
        step(1'b1, 8'h00);
        exp_v = {1'b0, 1'b1, 2'b00, 3'd0, 8'h00, 4'h1};
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL idle_illegal: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_up_walk();
        logic [7:0] r;
        do_reset();
        for (int i = 0; i <= 8; i++) begin
            r = 8'h01 << (i % 8);
            step(1'b1, r);
            exp_v = {1'b1, 1'b0, (i == 0) ? 2'b00 : 2'b01, 3'(i % 8),
                     (i == 8) ? 8'h01 : 8'h00, 4'h0};
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL up_walk[%0d]: got %h want %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_down();
        logic [7:0] seq [3];
        logic [1:0] edir [3];
        logic [2:0] epos [3];
        seq  = '{8'h80, 8'h40, 8'h80};
        edir = '{2'b10, 2'b10, 2'b01};
        epos = '{3'd7, 3'd6, 3'd7};
        do_reset();
        step(1'b1, 8'h01);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, seq[i]);
            exp_v = {1'b1, 1'b0, edir[i], epos[i], 8'hFF, 4'h0};
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL down[%0d]: got %h want %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_hold();
        do_reset();
        step(1'b1, 8'h04);
        step(1'b1, 8'h04);
        exp_v = {1'b1, 1'b0, 2'b00, 3'd2, 8'h00, 4'h0};
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step(1'b0, 8'h00);
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL hold[%0d]: got %h want %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_jump();
        do_reset();
        step(1'b1, 8'h02);
        step(1'b1, 8'h10);
        exp_v = {1'b1, 1'b1, 2'b11, 3'd4, 8'h00, 4'h1};
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL jump: got %h want %h", obs, exp_v);
        end
        step(1'b1, 8'h20);
        exp_v = {1'b1, 1'b0, 2'b01, 3'd5, 8'h00, 4'h1};
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL jump_resync: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_fault();
        logic [3:0] ecnt;
        do_reset();
        step(1'b1, 8'h01);
        step(1'b1, 8'h00);
        exp_v = {1'b0, 1'b1, 2'b00, 3'd0, 8'h00, 4'h1};
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL fault_enter: got %h want %h", obs, exp_v);
        end
        step(1'b1, 8'h03);
        exp_v = {1'b0, 1'b1, 2'b00, 3'd0, 8'h00, 4'h2};
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL fault_stay: got %h want %h", obs, exp_v);
        end
        step(1'b1, 8'h08);
        exp_v = {1'b1, 1'b0, 2'b00, 3'd3, 8'h00, 4'h2};
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL fault_relock: got %h want %h", obs, exp_v);
        end
        // First illegal word drops lock from pos 3; later ones stay in FAULT.
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, (i % 2 == 1) ? 8'hFF : 8'h00);
            ecnt  = (i + 2 > 15) ? 4'hF : 4'(i + 2);
            exp_v = {1'b0, 1'b1, 2'b00, 3'd3, 8'h00, ecnt};
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL err_sat[%0d]: got %h want %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_lap_wrap();
        logic [7:0] r;
        do_reset();
        step(1'b1, 8'h01);
        for (int rev = 1; rev <= 128; rev++) begin
            for (int b = 1; b <= 8; b++) begin
                r = 8'h01 << (b % 8);
                step(1'b1, r);
            end
            exp_v = {1'b1, 1'b0, 2'b01, 3'd0, 8'(rev), 4'h0};
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL lap_rev[%0d]: got %h want %h", rev, obs, exp_v);
            end
        end
        reset = 1'b1;
        step(1'b1, 8'h02);
        reset = 1'b0;
        exp_v = {1'b0, 1'b0, 2'b00, 3'd0, 8'h00, 4'h0};
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL mid_reset: got %h want %h", obs, exp_v);
        end
        step(1'b1, 8'h02);
        exp_v = {1'b1, 1'b0, 2'b00, 3'd1, 8'h00, 4'h0};
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL post_reset_lock: got %h want %h", obs, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_up_walk();
        test_down();
        test_hold();
        test_jump();
        test_fault();
        test_lap_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
